// File: rtl/bs_gnrtr_n_rbtr.sv
`default_nettype none
// ============================================================================
// bs_gnrtr_n_rbtr : round-robin shared-bus arbiter; pops one packet from a
// pending source FIFO and pushes it to the device named in its header.
// Optional feature macro: BS_BROADCAST_EN (ID == BROADCAST -> all but source)
// Revision: 1.0 - initial release
// ============================================================================
module bs_gnrtr_n_rbtr #(
  parameter int         BITS      = 1,
  parameter int         DRVRS     = 4,
  parameter int         PCKG_SZ   = 16,
  parameter logic [7:0] BROADCAST = 8'hFF
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [BITS-1:0][DRVRS-1:0]             pndng,
  input  logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0] D_pop,
  output logic [BITS-1:0][DRVRS-1:0]             pop,
  output logic [BITS-1:0][DRVRS-1:0]             push,
  output logic [BITS-1:0][PCKG_SZ-1:0]           D_push
);

  localparam int c_IW = $clog2(DRVRS);
`ifdef BS_BROADCAST_EN
  localparam bit c_BCAST_EN = 1'b1;
`else
  localparam bit c_BCAST_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_PUSH = 2'd2
  } state_t;

  for (genvar b = 0; b < BITS; b++) begin : g_bus
    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_IW-1:0]     r_rr_ptr;
    logic [c_IW-1:0]     w_rr_ptr_nxt;
    logic [c_IW-1:0]     r_src;
    logic [c_IW-1:0]     w_src_nxt;
    logic [c_IW-1:0]     w_sel;
    logic                w_found;
    logic [DRVRS-1:0]    r_pop;
    logic [DRVRS-1:0]    w_pop_nxt;
    logic [DRVRS-1:0]    r_push;
    logic [DRVRS-1:0]    w_push_nxt;
    logic [PCKG_SZ-1:0]  r_pkt;
    logic [PCKG_SZ-1:0]  w_pkt_nxt;
    logic [7:0]          w_dst;

    assign w_dst = D_pop[b][r_src][PCKG_SZ-1 -: 8];

    // Round-robin pick: first pending at/after r_rr_ptr, else first pending from 0.
    always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      for (int d = 0; d < DRVRS; d++) begin
        if (!w_found && pndng[b][d] && (d >= int'(r_rr_ptr))) begin
          w_found = 1'b1;
          w_sel   = c_IW'(d);
        end
      end
      for (int d = 0; d < DRVRS; d++) begin
        if (!w_found && pndng[b][d]) begin
          w_found = 1'b1;
          w_sel   = c_IW'(d);
        end
      end
    end

    always_comb begin
      w_state_nxt  = r_state;
      w_rr_ptr_nxt = r_rr_ptr;
      w_src_nxt    = r_src;
      w_pop_nxt    = '0;
      w_push_nxt   = '0;
      w_pkt_nxt    = r_pkt;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            w_state_nxt      = ST_POP;
            w_src_nxt        = w_sel;
            w_pop_nxt[w_sel] = 1'b1;
          end
        end
        ST_POP: begin
          w_state_nxt  = ST_PUSH;
          w_pkt_nxt    = D_pop[b][r_src];
          w_rr_ptr_nxt = (r_src == c_IW'(DRVRS - 1)) ? '0 : r_src + c_IW'(1);
          for (int d = 0; d < DRVRS; d++) begin
            if (w_dst < 8'(DRVRS)) begin
              w_push_nxt[d] = (w_dst == 8'(d));
            end else if (c_BCAST_EN && (w_dst == BROADCAST)) begin
              w_push_nxt[d] = (r_src != c_IW'(d));
            end
          end
        end
        ST_PUSH: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state  <= ST_IDLE;
        r_rr_ptr <= '0;
        r_src    <= '0;
        r_pop    <= '0;
        r_push   <= '0;
        r_pkt    <= '0;
      end else begin
        r_state  <= w_state_nxt;
        r_rr_ptr <= w_rr_ptr_nxt;
        r_src    <= w_src_nxt;
        r_pop    <= w_pop_nxt;
        r_push   <= w_push_nxt;
        r_pkt    <= w_pkt_nxt;
      end
    end

    assign pop[b]    = r_pop;
    assign push[b]   = r_push;
    assign D_push[b] = r_pkt;
  end

endmodule
`default_nettype wire

// File: tb/tb_bs_gnrtr_n_rbtr.sv
`default_nettype none
// ============================================================================
// tb_bs_gnrtr_n_rbtr : scoreboard bench for bs_gnrtr_n_rbtr, 8 devices, 16-bit packets
// Revision: 1.0 - initial release
// ============================================================================
module tb_bs_gnrtr_n_rbtr;

  localparam int BITS    = 1;
  localparam int DRVRS   = 8;
  localparam int PCKG_SZ = 16;
  localparam int DEPTH   = 64;

  logic                                    clk = 1'b0;
  logic                                    reset;
  logic [BITS-1:0][DRVRS-1:0]              pndng;
  logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0] D_pop;
  logic [BITS-1:0][DRVRS-1:0]              pop;
  logic [BITS-1:0][DRVRS-1:0]              push;
  logic [BITS-1:0][PCKG_SZ-1:0]            D_push;

  bs_gnrtr_n_rbtr #(
    .BITS     (BITS),
    .DRVRS    (DRVRS),
    .PCKG_SZ  (PCKG_SZ),
    .BROADCAST(8'hFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pndng (pndng),
    .D_pop (D_pop),
    .pop   (pop),
    .push  (push),
    .D_push(D_push)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          src;
    logic [15:0] pkt;
    logic [7:0]  mask;
  } exp_t;

  exp_t        expq[$];
  exp_t        cur;
  logic [15:0] mem [DRVRS][DEPTH];
  int          head [DRVRS];
  int          tail [DRVRS];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          load_cyc = 0;
  int          last_pop_cyc = -1;
  int          pend_pop = -1;
  int          m_rr = 0;
  bit          phase_first = 1'b0;
  bit          pend_push = 1'b0;
  bit          rand_drive = 1'b1;
  logic [15:0] m_last = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Delivery rule straight from the packet header.
  function automatic logic [7:0] expected_mask(input int src, input logic [15:0] pkt);
    int dst;
    dst = int'(pkt[15:8]);
    if (dst < DRVRS) return 8'(1 << dst);
`ifdef BS_BROADCAST_EN
    if (dst == 255) return ~(8'(1 << src));
`endif
    return 8'h00;
  endfunction

  // Drain the loaded FIFOs in round-robin order, producing the expected transfer list.
  task automatic build_expected();
    int   cursor [DRVRS];
    bit   any;
    int   s;
    exp_t e;
    for (int d = 0; d < DRVRS; d++) cursor[d] = head[d];
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      s   = 0;
      for (int k = 0; k < DRVRS; k++) begin
        if (!any && cursor[(m_rr + k) % DRVRS] != tail[(m_rr + k) % DRVRS]) begin
          any = 1'b1;
          s   = (m_rr + k) % DRVRS;
        end
      end
      if (any) begin
        e.src  = s;
        e.pkt  = mem[s][cursor[s]];
        e.mask = expected_mask(s, e.pkt);
        expq.push_back(e);
        cursor[s]++;
        m_rr = (s + 1) % DRVRS;
      end
    end
  endtask

  task automatic clear_fifos();
    for (int d = 0; d < DRVRS; d++) begin
      head[d] = 0;
      tail[d] = 0;
    end
  endtask

  task automatic add_pkt(input int d, input logic [15:0] p);
    mem[d][tail[d]] = p;
    tail[d]++;
  endtask

  task automatic start_phase();
    build_expected();
    load_cyc     = cyc;
    phase_first  = (expq.size() != 0);
    last_pop_cyc = -1;
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while ((expq.size() != 0 || pend_push) && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check("drain_timeout", 32'(expq.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [15:0] rand_pkt();
    int         sel;
    logic [7:0] dst;
    sel = int'($urandom_range(0, 9));
    if (sel <= 6)      dst = 8'($urandom_range(0, DRVRS - 1));
    else if (sel == 7) dst = 8'hFF;
    else if (sel == 8) dst = 8'($urandom_range(DRVRS, 254));
    else               dst = 8'($urandom);
    return {dst, 8'($urandom)};
  endfunction

  // Source FIFO model: first-word-fall-through, dequeued after the DUT's pop strobe.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pend_pop >= 0) begin
      head[pend_pop]++;
      pend_pop = -1;
    end
    for (int d = 0; d < DRVRS; d++) begin
      if (rand_drive) begin
        pndng[0][d] = 1'($urandom);
        D_pop[0][d] = 16'($urandom);
      end else begin
        pndng[0][d] = (head[d] != tail[d]);
        D_pop[0][d] = (head[d] != tail[d]) ? mem[d][head[d]] : 16'($urandom);
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      check("rst_pop", 32'(pop[0]), 32'd0);
      check("rst_push", 32'(push[0]), 32'd0);
      check("rst_d_push", 32'(D_push[0]), 32'd0);
    end else begin
      check("pop_push_overlap", 32'((pop[0] != '0) && (push[0] != '0)), 32'd0);
      if (pend_push) begin
        check("push_mask", 32'(push[0]), 32'(cur.mask));
        check("d_push", 32'(D_push[0]), 32'(cur.pkt));
        m_last    = cur.pkt;
        pend_push = 1'b0;
      end else begin
        check("push_idle", 32'(push[0]), 32'd0);
        check("d_push_hold", 32'(D_push[0]), 32'(m_last));
      end
      if (pop[0] != '0) begin
        check("pop_onehot", 32'($onehot(pop[0])), 32'd1);
        for (int d = 0; d < DRVRS; d++) if (pop[0][d]) pend_pop = d;
        if (expq.size() == 0) begin
          check("pop_unexpected", 32'(pop[0]), 32'd0);
        end else begin
          cur = expq.pop_front();
          check("pop_src", 32'(pop[0]), 32'(1 << cur.src));
          if (phase_first)            check("pop_latency", 32'(cyc - load_cyc), 32'd2);
          else if (last_pop_cyc >= 0) check("pop_gap", 32'(cyc - last_pop_cyc), 32'd3);
          phase_first  = 1'b0;
          last_pop_cyc = cyc;
          pend_push    = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset = 1'b1;
    pndng = '0;
    D_pop = '0;
    clear_fifos();
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    rand_drive = 1'b0;
    @(posedge clk);
    #2;
    @(negedge clk);
    #1 reset = 1'b1;
    wait_drain();

    // Unicast to device 3.
    @(negedge clk); clear_fifos(); add_pkt(0, 16'h03A5); start_phase(); wait_drain();
    // Broadcast from device 5 (dropped when broadcast is disabled).
    @(negedge clk); clear_fifos(); add_pkt(5, 16'hFF12); start_phase(); wait_drain();
    // Out-of-range destination.
    @(negedge clk); clear_fifos(); add_pkt(2, 16'h0A00); start_phase(); wait_drain();
    // All sources pending, every packet to device 0.
    @(negedge clk); clear_fifos();
    for (int d = 0; d < DRVRS; d++) begin
      add_pkt(d, {8'h00, 8'(d)});
      add_pkt(d, {8'h00, 8'(d + 16)});
    end
    start_phase(); wait_drain();

    // Reset asserted during the POP cycle.
    @(negedge clk); clear_fifos(); add_pkt(2, 16'h0355); add_pkt(6, 16'h0177); start_phase();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (pop[0] != '0) seen = 1'b1;
    end
    check("midrst_pop_seen", 32'(seen), 32'd1);
    #1;
    reset        = 1'b0;
    pend_push    = 1'b0;
    pend_pop     = -1;
    expq.delete();
    m_rr         = 0;
    m_last       = 16'h0;
    phase_first  = 1'b0;
    last_pop_cyc = -1;
    repeat (3) @(negedge clk);
    build_expected();
    #1 reset = 1'b1;
    wait_drain();

    // Randomized traffic.
    for (int ph = 0; ph < 30; ph++) begin
      int total;
      @(negedge clk);
      clear_fifos();
      total = 0;
      for (int d = 0; d < DRVRS; d++) begin
        int n;
        n = int'($urandom_range(0, 3));
        for (int k = 0; k < n; k++) add_pkt(d, rand_pkt());
        total += n;
      end
      if (total == 0) add_pkt(int'($urandom_range(0, DRVRS - 1)), rand_pkt());
      start_phase();
      wait_drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
